mpu_matrix_loader: RTL and testbench
====================================

# mpu_matrix_loader

Serial-to-parallel operand loader for the matrix processing unit's determinant stage. Accepts a matrix size, then n×n signed 8-bit elements one per handshake in row-major order, and assembles them into the packed 5×5 matrix word plus size byte consumed directly by the determinant stage. Holds the assembled operand with a valid/ready handshake until the downstream stage takes it.

## Interface
- No parameters; element width 8, matrix dimension 5 fixed via package constants.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  request a new load; sampled only in IDLE
- size_in  in  8  signed matrix size n, legal 1..5; sampled with start
- in_valid  in  1  element present on in_data
- in_data  in  8  signed element
- in_ready  out  1  loader accepts element this cycle
- matrix  out  200  packed matrix; element (r,c) at bits [r*40 + c*8 +: 8]
- size  out  8  latched n
- out_valid  out  1  matrix/size complete and stable
- out_ready  in  1  downstream consumes operand
- busy  out  1  high in any state other than IDLE
- error  out  1  one-cycle pulse on illegal size_in at start

## Operation
- States: IDLE, LOAD, HOLD.
- IDLE: start && 1 ≤ size_in ≤ 5 → latch size, clear matrix to all zero, row=col=0, go LOAD. start with size_in ≤ 0 or > 5 → error=1 next cycle, stay IDLE, matrix/size unchanged.
- LOAD: in_ready=1. On in_valid && in_ready write in_data to (row,col); col increments; when col == n−1, col wraps to 0 and row increments. Handshake on (n−1,n−1) → HOLD.
- Entries outside the n×n top-left block remain zero.
- HOLD: out_valid=1; matrix and size frozen. out_ready → IDLE, out_valid drops next cycle.
- start outside IDLE is ignored (no error, no restart).
- in_valid outside LOAD is ignored; no element is consumed.
- Sizes 4 and 5 load normally; the determinant stage returns 0 for them, which is not this block's concern.
- Counters row/col 3 bits each; size compare signed 8-bit.

## Timing
- Reset values: state IDLE, matrix 0, size 0, in_ready 0, out_valid 0, busy 0, error 0, row/col 0.
- reset takes priority over all inputs; reset mid-LOAD or mid-HOLD discards the partial or held matrix.
- start accepted at cycle t → LOAD and in_ready=1 at t+1.
- in_ready is a pure function of state (no combinational path from in_valid).
- With in_valid held high, n² elements are accepted in n² consecutive cycles; gaps in in_valid stall without loss.
- Last element accepted at cycle t → out_valid=1 at t+1.
- out_ready sampled at t with out_valid=1 → IDLE at t+1; earliest next start accepted at t+1.
- out_ready while not in HOLD has no effect.
- Minimum start-to-start period n² + 2 cycles when out_ready is tied high.

## Structure
- Shared package mpu_pkg: ELEM_W=8, DIM=5, MAT_W=200, state enum, element offset function (row, col → r*40+c*8).
- Determinant stage imports the same package for MAT_W and the offset layout.
- One sub-module natural: mpu_index_counter (row/col counter with wrap at n−1, clear, last-element flag).

## Test plan
- Reset mid-LOAD after 3 of 9 elements → all outputs return to reset values; a new start with size 2 loads cleanly.
- start size 3, stream 1..9 back-to-back → out_valid 10 cycles after start acceptance; matrix (0,0)=1, (1,2)=6, (2,2)=9, others 0; determinant stage yields 0.
- start size 2, elements 3,−2,4,5 with in_valid gaps of 2 cycles, out_ready held low 5 cycles → matrix stable throughout HOLD; (1,0)=4, (0,1)=8'hFE; det=23.
- start with size_in 0, then 6, then −1 → three error pulses, busy stays 0, in_ready stays 0.
- start size 1 with element −7, out_ready tied high → out_valid for exactly one cycle, matrix[7:0]=8'hF9; next start accepted on the following cycle.
- start asserted during LOAD and HOLD → ignored; size and element count unchanged.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared constants, state encoding and packed-matrix layout for the MPU operand path.
package mpu_pkg;

  localparam int ELEM_W = 8;
  localparam int DIM    = 5;
  localparam int MAT_W  = DIM * DIM * ELEM_W;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Bit offset of element (row, col); 192 is the largest value, so 8 bits suffice.
  function automatic logic [7:0] elem_offset(input logic [IDX_W-1:0] row,
                                             input logic [IDX_W-1:0] col);
    return (8'(row) * 8'(DIM * ELEM_W)) + (8'(col) * 8'(ELEM_W));
  endfunction

endpackage

// File: rtl/mpu_index_counter.sv
// Row-major row/col index counter for an n x n block, with wrap at n-1 and last-element flag.
module mpu_index_counter
  import mpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  input  logic [IDX_W-1:0] n,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  logic [IDX_W-1:0] n_m1;

  assign n_m1 = n - IDX_W'(1);
  assign last = (row == n_m1) && (col == n_m1);

  always_ff @(posedge clk) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == n_m1) begin
        col <= '0;
        row <= row + IDX_W'(1);
      end else begin
        col <= col + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/mpu_matrix_loader.sv
// Serial-to-parallel loader: collects n*n signed elements row-major into the packed
// 5x5 operand word and holds it with size under a valid/ready handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; illegal size pulses error
//   ST_LOAD | in_ready high, one element written per in_valid
//   ST_HOLD | out_valid high, operand frozen until out_ready
module mpu_matrix_loader
  import mpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        size_in,
  input  logic              in_valid,
  input  logic [ELEM_W-1:0] in_data,
  output logic              in_ready,
  output logic [MAT_W-1:0]  matrix,
  output logic [7:0]        size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              error
);

  state_e           state_q, state_d;
  logic [MAT_W-1:0] matrix_q;
  logic [7:0]       size_q;
  logic             error_q;
  logic             err_d;
  logic             load_start;
  logic             accept;
  logic             size_legal;
  logic [IDX_W-1:0] row, col;
  logic             last;

  assign size_legal = ($signed(size_in) >= 8'sd1) && ($signed(size_in) <= 8'sd5);

  mpu_index_counter u_idx (
    .clk     (clk),
    .reset   (reset),
    .clear   (load_start),
    .advance (accept),
    .n       (size_q[IDX_W-1:0]),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load_start = 1'b0;
    accept     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (size_legal) begin
            load_start = 1'b1;
            state_d    = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (last) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Matrix is cleared at start so entries outside the n x n block read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      matrix_q <= '0;
      size_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      error_q <= err_d;
      if (load_start) begin
        size_q   <= size_in;
        matrix_q <= '0;
      end else if (accept) begin
        matrix_q[elem_offset(row, col) +: ELEM_W] <= in_data;
      end
    end
  end

  assign matrix = matrix_q;
  assign size   = size_q;
  assign error  = error_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Scoreboard bench for mpu_matrix_loader: stimulus queues expected operands, a monitor
// compares them at each out_valid/out_ready handshake.
module tb_mpu_matrix_loader;

  typedef struct {
    logic [199:0] m;
    logic [7:0]   s;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   size_in;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [199:0] matrix;
  logic [7:0]   size;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         error;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           err_seen = 0;
  logic [199:0] last_m = '0;
  logic [7:0]   last_s = '0;
  logic [7:0]   el[$];
  logic [7:0]   bad_sizes[3];

  always #5 clk = ~clk;

  mpu_matrix_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .size_in   (size_in),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .matrix    (matrix),
    .size      (size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .error     (error)
  );

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [199:0] build(input int n, input logic [7:0] e[$]);
    logic [199:0] m;
    m = '0;
    for (int i = 0; i < n * n; i++) m[(i / n) * 40 + (i % n) * 8 +: 8] = e[i];
    return m;
  endfunction

  always @(negedge clk) begin
    if (!reset && error) err_seen++;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got operand of size %0d, required none pending", size);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_matrix", matrix, mon_e.m);
        chk("sb_size", 200'(size), 200'(mon_e.s));
      end
    end
  end

  task automatic load(input int n, input logic [7:0] e[$], input int gap, input int hold,
                      input bit tied, input bit ign);
    logic [199:0] em;
    em        = build(n, e);
    out_ready = tied;
    start     = 1'b1;
    size_in   = 8'(n);
    tick();
    if (ign) size_in = 8'd4;
    else     start   = 1'b0;
    chk("busy_after_start", 200'(busy), 200'(1));
    chk("in_ready_after_start", 200'(in_ready), 200'(1));
    sb.push_back('{m: em, s: 8'(n)});
    for (int i = 0; i < n * n; i++) begin
      for (int g = 0; i > 0 && g < gap; g++) begin
        in_valid = 1'b0;
        tick();
        chk("in_ready_in_gap", 200'(in_ready), 200'(1));
      end
      chk("out_valid_during_load", 200'(out_valid), 200'(0));
      if (ign) chk("error_start_in_load", 200'(error), 200'(0));
      in_valid = 1'b1;
      in_data  = e[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = 8'd0;
    chk("out_valid_after_last", 200'(out_valid), 200'(1));
    chk("in_ready_in_hold", 200'(in_ready), 200'(0));
    if (ign) size_in = 8'd0;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_matrix_stable", matrix, em);
      chk("hold_out_valid", 200'(out_valid), 200'(1));
      if (ign) chk("error_start_in_hold", 200'(error), 200'(0));
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("out_valid_after_take", 200'(out_valid), 200'(0));
    chk("busy_after_take", 200'(busy), 200'(0));
    if (!tied) out_ready = 1'b0;
    last_m = em;
    last_s = 8'(n);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    size_in   = 8'd0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_matrix", matrix, '0);
    chk("rst_size", 200'(size), 200'(0));
    chk("rst_in_ready", 200'(in_ready), 200'(0));
    chk("rst_out_valid", 200'(out_valid), 200'(0));
    chk("rst_busy", 200'(busy), 200'(0));
    chk("rst_error", 200'(error), 200'(0));

    // reset in the middle of a 3x3 load after three elements
    start   = 1'b1;
    size_in = 8'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(11 + i);
      tick();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_matrix", matrix, '0);
    chk("midrst_size", 200'(size), 200'(0));
    chk("midrst_busy", 200'(busy), 200'(0));
    chk("midrst_in_ready", 200'(in_ready), 200'(0));
    chk("midrst_out_valid", 200'(out_valid), 200'(0));

    el = '{8'd10, 8'd20, 8'd30, 8'd40};
    load(2, el, 0, 1, 1'b0, 1'b0);
    chk("sz2_elem_1_0", 200'(matrix[47:40]), 200'(30));

    el = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    load(3, el, 0, 2, 1'b0, 1'b0);
    chk("sz3_elem_0_0", 200'(matrix[7:0]), 200'(1));
    chk("sz3_elem_1_2", 200'(matrix[56 +: 8]), 200'(6));
    chk("sz3_elem_2_2", 200'(matrix[96 +: 8]), 200'(9));
    chk("sz3_outside_zero", 200'(matrix[199:104]), 200'(0));

    el = '{8'd3, 8'hFE, 8'd4, 8'd5};
    load(2, el, 2, 5, 1'b0, 1'b0);
    chk("gap_elem_1_0", 200'(matrix[47:40]), 200'(4));
    chk("gap_elem_0_1", 200'(matrix[15:8]), 200'(8'hFE));

    bad_sizes = '{8'd0, 8'd6, 8'hFF};
    for (int k = 0; k < 3; k++) begin
      start   = 1'b1;
      size_in = bad_sizes[k];
      tick();
      start = 1'b0;
      chk("err_pulse", 200'(error), 200'(1));
      chk("err_busy", 200'(busy), 200'(0));
      chk("err_in_ready", 200'(in_ready), 200'(0));
      chk("err_matrix_kept", matrix, last_m);
      chk("err_size_kept", 200'(size), 200'(last_s));
      tick();
      chk("err_one_cycle", 200'(error), 200'(0));
    end

    el = '{8'hF9};
    load(1, el, 0, 0, 1'b1, 1'b0);
    chk("sz1_elem", 200'(matrix[7:0]), 200'(8'hF9));
    el = '{8'd1, 8'd2, 8'd3, 8'd4};
    load(2, el, 0, 0, 1'b1, 1'b0);
    out_ready = 1'b0;

    el = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    load(3, el, 1, 3, 1'b0, 1'b1);
    chk("ign_size", 200'(size), 200'(3));

    tick();
    chk("sb_drained", 200'(sb.size()), 200'(0));
    chk("error_pulse_count", 200'(err_seen), 200'(3));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
